// File: rtl/ic_refill_rd.sv
// Instruction-cache refill read master: one 4-beat INCR burst per request,
// beats assembled into a 128-bit line, with pipeline-reset drain and a one-entry restart latch.
module ic_refill_rd #(
   parameter logic [3:0] ARID_VAL = 4'h1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rst_pipe,
   input  logic         icr_start_rq,
   input  logic [31:0]  ic_rin_addr,
   output logic         ic_rdat_m_valid,
   output logic [127:0] rdat_m_data,
   output logic         ic_finish_mrd,
   output logic         ic_rd_err,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready
);

   typedef enum logic [2:0] {IDLE, AREQ, RDAT, DONE, FIN} state_t;

   state_t      state, state_nx;
   logic [1:0]  beat_cnt;
   logic        abort, fin_sup, err_sticky, pend_vld;
   logic [27:0] pend_addr, line_addr;
   logic        ar_hs, r_hs, last_beat, busy, abort_now, start;
   logic        unused_bits;

   assign ar_hs     = arvalid & arready;
   assign r_hs      = rvalid & rready;
   assign last_beat = r_hs & (beat_cnt == 2'd3);
   assign busy      = (state == AREQ) | (state == RDAT);
   // A pipeline reset seen on the final beat still counts as an abort.
   assign abort_now = abort | (busy & rst_pipe);
   // A pipeline reset in IDLE drops a pending restart unless a new request arrives with it.
   assign start     = icr_start_rq | (pend_vld & ~rst_pipe);

   assign arid        = ARID_VAL;
   assign araddr      = {line_addr, 4'h0};
   assign arlen       = 8'd3;
   assign arsize      = 3'd2;
   assign arburst     = 2'b01;
   assign unused_bits = ^{rlast, ic_rin_addr[3:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = AREQ;
         AREQ:    if (ar_hs) state_nx = RDAT;
         RDAT:    if (last_beat) state_nx = abort_now ? IDLE : DONE;
         DONE:    state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      arvalid         = (state == AREQ);
      rready          = (state == RDAT);
      ic_rdat_m_valid = (state == DONE) & ~rst_pipe;
      ic_finish_mrd   = (state == FIN) & ~fin_sup;
      ic_rd_err       = ic_rdat_m_valid & err_sticky;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt   <= 2'd0;
         abort      <= 1'b0;
         fin_sup    <= 1'b0;
         err_sticky <= 1'b0;
         pend_vld   <= 1'b0;
         pend_addr  <= 28'd0;
         line_addr  <= 28'd0;
      end else begin
         if ((state == IDLE) && start) begin
            line_addr  <= pend_vld ? pend_addr : ic_rin_addr[31:4];
            beat_cnt   <= 2'd0;
            err_sticky <= 1'b0;
         end
         if (r_hs) begin
            beat_cnt   <= beat_cnt + 2'd1;
            err_sticky <= err_sticky | (rresp != 2'b00);
         end

         if (last_beat)            abort <= 1'b0;
         else if (busy & rst_pipe) abort <= 1'b1;

         fin_sup <= (state == DONE) & rst_pipe;

         // Requests arriving while a drain is outstanding are parked until it ends.
         if (icr_start_rq & abort_now) begin
            pend_vld  <= 1'b1;
            pend_addr <= ic_rin_addr[31:4];
         end else if ((state == IDLE) && start) begin
            pend_vld <= 1'b0;
         end else if (rst_pipe && ((state == IDLE) || (state == FIN))) begin
            pend_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    rdat_m_data <= 128'd0;
      else if (r_hs) rdat_m_data[{beat_cnt, 5'd0} +: 32] <= rdata;
   end

endmodule

// File: tb/tb_ic_refill_rd.sv
// Bench for ic_refill_rd: behavioural AXI read slave plus line/address scoreboards.
module tb_ic_refill_rd;

   logic         clk = 1'b0;
   logic         rst_n, rst_pipe, icr_start_rq;
   logic [31:0]  ic_rin_addr;
   logic         ic_rdat_m_valid, ic_finish_mrd, ic_rd_err;
   logic [127:0] rdat_m_data;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid, arready, rvalid, rready, rlast;
   logic [31:0]  rdata;
   logic [1:0]   rresp;

   ic_refill_rd #(.ARID_VAL(4'h1)) dut (
      .clk(clk), .rst_n(rst_n), .rst_pipe(rst_pipe),
      .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr),
      .ic_rdat_m_valid(ic_rdat_m_valid), .rdat_m_data(rdat_m_data),
      .ic_finish_mrd(ic_finish_mrd), .ic_rd_err(ic_rd_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] bdata(input int k, input int j);
      if (k < 2) return 32'h11 * 32'(j + 1);
      return 32'hA000_0000 | (32'(k) << 8) | 32'(j);
   endfunction

   function automatic logic [1:0] bresp(input int k, input int j);
      return (k == 2 && j == 2) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [128:0] exp_line(input int k);
      logic [128:0] e;
      e = '0;
      for (int j = 0; j < 4; j++) begin
         e[j*32 +: 32] = bdata(k, j);
         if (bresp(k, j) != 2'b00) e[128] = 1'b1;
      end
      return e;
   endfunction

   logic [128:0] line_q[$];
   logic [31:0]  addr_q[$];

   // Monitor: handshake bookkeeping and scoreboard comparisons.
   bit           ar_fire, r_fire, arv_prev, v_prev;
   logic [31:0]  ar_prev_addr, ea;
   logic [128:0] el;
   int           n_beats = 0, n_valid = 0, n_fin = 0;
   int           t_valid = 0, t_fin = 0, t_arv = 0, t_rfire = 0;

   always @(negedge clk) begin
      ar_fire = arvalid & arready;
      r_fire  = rvalid & rready;
      if (rst_n) begin
         if (ar_fire) begin
            if (addr_q.size() == 0) check("unexp_ar", 1, 0);
            else begin
               ea = addr_q.pop_front();
               check("araddr", araddr, ea);
            end
            check("arlen", arlen, 8'd3);
            check("arsize", arsize, 3'd2);
            check("arburst", arburst, 2'b01);
            check("arid", arid, 4'h1);
         end
         if (arvalid && arv_prev) check("araddr_stable", araddr, ar_prev_addr);
         if (arvalid && !arv_prev) t_arv = cyc;
         if (r_fire) begin
            n_beats++;
            t_rfire = cyc;
         end
         if (ic_rdat_m_valid) begin
            n_valid++;
            t_valid = cyc;
            if (line_q.size() == 0) check("unexp_valid", 1, 0);
            else begin
               el = line_q.pop_front();
               check("line_data", rdat_m_data, el[127:0]);
               check("line_err", ic_rd_err, el[128]);
            end
         end else begin
            check("err_no_valid", ic_rd_err, 0);
         end
         if (ic_finish_mrd) begin
            n_fin++;
            t_fin = cyc;
            check("fin_after_valid", v_prev, 1);
         end
         if (v_prev) check("fin_follows_valid", ic_finish_mrd, 1);
      end
      arv_prev     = arvalid;
      ar_prev_addr = araddr;
      v_prev       = ic_rdat_m_valid;
   end

   // AXI read slave, driven just after each rising edge.
   int ar_stall_cfg;
   bit r_gap;

   initial begin : axi_slave
      int bt, sk, stalled;
      bit in_burst, gph;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      bt = 0; sk = 0; stalled = 0; in_burst = 0; gph = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            if (in_burst) sk++;
            in_burst = 0; stalled = 0;
            arready = 0; rvalid = 0; rlast = 0;
         end else begin
            if (ar_fire) begin
               in_burst = 1; bt = 0; gph = 1; stalled = 0;
            end else if (r_fire) begin
               bt++;
               if (bt == 4) begin
                  in_burst = 0;
                  sk++;
               end
            end
            arready = arvalid && !in_burst && (stalled >= ar_stall_cfg);
            if (arvalid && !in_burst && !arready) stalled++;
            if (in_burst) begin
               rvalid = r_gap ? gph : 1'b1;
               gph    = ~gph;
               rdata  = rvalid ? bdata(sk, bt) : $urandom;
               rresp  = rvalid ? bresp(sk, bt) : 2'b11;
               rlast  = (bt == 3);
            end else begin
               rvalid = 0;
               rlast  = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic request(input logic [31:0] a);
      icr_start_rq = 1'b1;
      ic_rin_addr  = a;
      tick();
      icr_start_rq = 1'b0;
      ic_rin_addr  = $urandom;
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wait_beats(input int n, input int maxc);
      int c = 0;
      while (n_beats < n && c < maxc) begin
         tick();
         c++;
      end
      if (n_beats < n) check("tmo_beats", n_beats, n);
   endtask

   task automatic wait_idle(input int maxc);
      int  c = 0;
      bit  busy_now;
      busy_now = 1;
      while (busy_now && c < maxc) begin
         busy_now = (line_q.size() != 0) || arvalid || rready || ic_rdat_m_valid || ic_finish_mrd;
         if (busy_now) begin
            tick();
            c++;
         end
      end
      if (busy_now) check("tmo_idle", 0, 1);
   endtask

   initial begin : main
      int t0, nb, nv, nf, tl;
      rst_n = 0; rst_pipe = 0; icr_start_rq = 0; ic_rin_addr = 0;
      ar_stall_cfg = 0; r_gap = 0;
      repeat (3) tick();
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_valid", ic_rdat_m_valid, 0);
      check("rst_fin", ic_finish_mrd, 0);
      check("rst_err", ic_rd_err, 0);
      check("rst_data", rdat_m_data, 0);
      check("rst_araddr", araddr, 0);
      check("rst_arid", arid, 4'h1);
      check("rst_arlen", arlen, 8'd3);
      check("rst_arsize", arsize, 3'd2);
      check("rst_arburst", arburst, 2'b01);
      rst_n = 1;
      tick();

      // basic zero-wait refill
      addr_q.push_back(32'h0000_1230);
      line_q.push_back(exp_line(0));
      t0 = cyc;
      request(32'h0000_1234);
      check("basic_arvalid_rise", arvalid, 1);
      wait_cycle(t0 + 8);
      check("basic_line", rdat_m_data, 128'h00000044_00000033_00000022_00000011);
      check("basic_valid_lat", t_valid - t0, 6);
      check("basic_fin_lat", t_fin - t0, 7);

      // back-to-back request at T8 with backpressure
      ar_stall_cfg = 3; r_gap = 1;
      addr_q.push_back(32'h0000_5670);
      line_q.push_back(exp_line(1));
      nv = n_valid;
      request(32'h0000_5678);
      check("b2b_arvalid", arvalid, 1);
      wait_idle(80);
      check("bp_one_valid", n_valid - nv, 1);
      ar_stall_cfg = 0; r_gap = 0;

      // error response on beat2, then a clean refill
      addr_q.push_back(32'h0000_8AB0);
      line_q.push_back(exp_line(2));
      request(32'h0000_8ABC);
      wait_idle(40);
      addr_q.push_back(32'h0000_9000);
      line_q.push_back(exp_line(3));
      request(32'h0000_9000);
      wait_idle(40);

      // abort after beat1: drain, nothing delivered
      addr_q.push_back(32'h0000_A000);
      nv = n_valid; nf = n_fin; nb = n_beats;
      request(32'h0000_A004);
      wait_beats(nb + 2, 40);
      rst_pipe = 1;
      tick();
      rst_pipe = 0;
      wait_beats(nb + 4, 40);
      check("abort_idle_rready", rready, 0);
      check("abort_idle_arvalid", arvalid, 0);
      wait_cycle(cyc + 6);
      check("abort_no_valid", n_valid - nv, 0);
      check("abort_no_fin", n_fin - nf, 0);

      // abort in AREQ, new request during the drain
      addr_q.push_back(32'h0000_B000);
      nv = n_valid; nb = n_beats;
      ar_stall_cfg = 3;
      request(32'h0000_B000);
      rst_pipe = 1;
      tick();
      rst_pipe = 0;
      wait_beats(nb + 1, 40);
      ar_stall_cfg = 0;
      addr_q.push_back(32'h0000_2000);
      line_q.push_back(exp_line(6));
      request(32'h0000_2000);
      wait_beats(nb + 4, 40);
      tl = t_rfire;
      wait_idle(60);
      check("restart_arvalid", t_arv - tl, 2);
      check("abort_req_one_valid", n_valid - nv, 1);

      // reset mid-burst
      addr_q.push_back(32'h0000_C000);
      nb = n_beats;
      request(32'h0000_C000);
      wait_beats(nb + 1, 40);
      rst_n = 0;
      tick();
      check("mrst_arvalid", arvalid, 0);
      check("mrst_rready", rready, 0);
      check("mrst_valid", ic_rdat_m_valid, 0);
      check("mrst_fin", ic_finish_mrd, 0);
      check("mrst_err", ic_rd_err, 0);
      check("mrst_data", rdat_m_data, 0);
      check("mrst_araddr", araddr, 0);
      tick();
      rst_n = 1;
      tick();

      // recovery refill
      addr_q.push_back(32'h0000_D000);
      line_q.push_back(exp_line(8));
      request(32'h0000_D00C);
      wait_idle(40);

      check("line_q_empty", line_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ic_refill_rd.md
# ic_refill_rd

Instruction-cache refill read master sitting directly downstream of the instruction lookup stage. It accepts a one-cycle refill request (`icr_start_rq`, `ic_rin_addr`), issues a single 4-beat INCR burst on the tiny AXI read bus, and assembles the 32-bit beats into a 128-bit line. It returns the line to the lookup stage/IC RAM with a one-cycle `ic_rdat_m_valid` strobe, followed by `ic_finish_mrd`. It also survives pipeline resets that arrive while a burst is outstanding.

## Interface
- `ARID_VAL`, default 4'h1: constant driven on `arid`.

- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rst_pipe`  in  1  pipeline reset; aborts delivery of the current refill, not the AXI transaction.
- `icr_start_rq`  in  1  one-cycle refill request pulse.
- `ic_rin_addr`  in  32  refill byte address; bits [3:0] ignored.
- `ic_rdat_m_valid`  out  1  one-cycle strobe: `rdat_m_data` holds a complete line.
- `rdat_m_data`  out  128  assembled line; beat0 in [31:0], beat3 in [127:96].
- `ic_finish_mrd`  out  1  one-cycle pulse, the cycle after `ic_rdat_m_valid`.
- `ic_rd_err`  out  1  high with `ic_rdat_m_valid` if any beat had `rresp != 0`.
- `arid`  out  4  = `ARID_VAL`.
- `araddr`  out  32  `{addr[31:4], 4'h0}`.
- `arlen`  out  8  constant 8'd3.
- `arsize`  out  3  constant 3'd2.
- `arburst`  out  2  constant 2'b01.
- `arvalid`  out  1  read address valid.
- `arready`  in  1  read address ready.
- `rdata`  in  32  read data beat.
- `rresp`  in  2  read response.
- `rlast`  in  1  last beat marker; informational, not used for sequencing.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  read data ready.

## Operation
- States:
  - IDLE: waiting for a request.
  - AREQ: `arvalid` high.
  - RDAT: `rready` high.
  - DONE: `ic_rdat_m_valid` high.
  - FIN: `ic_finish_mrd` high.
- Transitions:
  - IDLE -> AREQ: on `icr_start_rq`, or when the pending latch is valid. Capture the address from the pending latch if valid, else from `ic_rin_addr`.
  - AREQ -> RDAT: on `arvalid & arready`.
  - RDAT: each `rvalid & rready` writes `rdata` into slot `beat_cnt` and increments the 2-bit `beat_cnt`.
  - RDAT, on the handshake with `beat_cnt == 3`: go to DONE, or to IDLE if the abort flag is set.
  - DONE -> FIN -> IDLE, unconditionally.
- `araddr` holds constant for the whole AREQ state; `arvalid` never drops before the handshake.
- Error handling: the `rresp` error sticky is cleared on entering AREQ and ORed each beat. It drives `ic_rd_err` in DONE. The line is still delivered.
- `rdat_m_data` holds its value after DONE until the next beat0 write.
- `icr_start_rq` while busy with no abort pending: ignored. The lookup stage guarantees this does not occur.
- `rst_pipe` in AREQ or RDAT:
  - Set the abort flag.
  - The AXI transaction completes normally: the `arvalid` handshake still occurs and all 4 beats are accepted.
  - `ic_rdat_m_valid`, `ic_finish_mrd` and `ic_rd_err` are suppressed.
  - Return to IDLE after beat 3, then clear the abort flag.
- `rst_pipe` in DONE: `ic_rdat_m_valid` is suppressed that cycle; FIN still occurs with `ic_finish_mrd` suppressed.
- `rst_pipe` in FIN or IDLE: no effect. It also clears the pending latch unless `icr_start_rq` is high in the same cycle.
- Pending latch (1 entry):
  - Loads `ic_rin_addr` when `icr_start_rq` arrives while the abort flag is set.
  - A second request while the latch is valid overwrites it.
  - Serviced on the IDLE cycle after the drain completes.
- `rst_pipe` and `icr_start_rq` in the same cycle while busy: the abort is set and the request is latched.
- `rst_n` low: all state, counter, flags and latch cleared synchronously, and all outputs return to reset values. An in-flight burst is abandoned; the interconnect is reset together with this block.

## Timing
- Reset values:
  - `arvalid`, `rready`, `ic_rdat_m_valid`, `ic_finish_mrd`, `ic_rd_err`: 0.
  - `rdat_m_data`, `araddr`: 0.
  - Constant AR fields as listed.
- `arvalid` rises the cycle after `icr_start_rq`.
- `rready` is high throughout RDAT, combinationally from state.
- Minimum latency, with `arready` and `rvalid` tied high:
  - Request at T0, AR handshake at T1.
  - Beats at T2..T5.
  - `ic_rdat_m_valid` at T6, `ic_finish_mrd` at T7.
  - IDLE at T8; the next request is accepted at T8.
- Stalls in `arready`/`rvalid` extend AREQ/RDAT cycle-for-cycle. There are no timeouts.
- Pending-latch restart: `arvalid` rises 2 cycles after the final drained beat (1 IDLE cycle).

## Test plan
- Basic refill: `ic_rin_addr`=0x0000_1234, beats 0x11,0x22,0x33,0x44, zero-wait -> `araddr`=0x0000_1230, `arlen`=3; `rdat_m_data`=0x00000044_00000033_00000022_00000011; `ic_rdat_m_valid` at T6, `ic_finish_mrd` at T7.
- Backpressure: `arready` low 3 cycles, `rvalid` gapped 1-0-1-0 -> `araddr` stable throughout, same data, `ic_rdat_m_valid` exactly once.
- Error response: beat2 `rresp`=2'b10 -> `ic_rd_err`=1 coincident with `ic_rdat_m_valid`; the next clean refill gives `ic_rd_err`=0.
- Abort mid-burst: `rst_pipe` after beat1 -> all 4 beats accepted, no `ic_rdat_m_valid`/`ic_finish_mrd`; IDLE after beat3.
- Abort plus new request: `rst_pipe` in AREQ, then `icr_start_rq` with 0x0000_2000 during drain -> after the drain, new `araddr`=0x0000_2000, and only the second line is delivered.
- Reset: `rst_n` low during RDAT -> next cycle all outputs at reset values and state IDLE.
